aes_round_sequencer: RTL and testbench
======================================

# aes_round_sequencer

Iterative AES round controller that owns the 128-bit state register and sequences one block through the initial key whitening (state XOR round key 0) and NR cipher rounds. It requests round keys from the key-schedule storage by index, drives the shared external round-function datapath (SubBytes/ShiftRows/MixColumns + key add), and moves blocks in and out through valid/ready handshakes. It sits between the block I/O interface and the round datapath, one instance per cipher core.

## Interface
- NR, 10, number of rounds; legal values 10, 12, 14 (AES-128/192/256).
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous abort; returns FSM to IDLE at next edge.
- key_ready  in  1  key schedule complete and stable; gates block acceptance only.
- in_valid  in  1  input block valid.
- in_ready  out  1  sequencer accepts a block this cycle.
- in_data  in  128  plaintext block.
- rk_idx  out  4  round-key index requested this cycle.
- rk  in  128  round key for rk_idx, combinational same-cycle response.
- rnd_state  out  128  current state register to round datapath.
- rnd_final  out  1  current round is the last (datapath skips MixColumns).
- rnd_out  in  128  combinational result of the round datapath for rnd_state/rk/rnd_final.
- out_valid  out  1  result block valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  128  result block (equals state register).
- busy  out  1  FSM not in IDLE.

## Operation
- States: IDLE, ROUND, DONE. Round counter rnd, 4 bits.
- IDLE: rk_idx=0; in_ready = key_ready. On in_valid&in_ready: state <= in_data ^ rk, rnd <= 1, go ROUND.
- ROUND: rk_idx=rnd; rnd_final = (rnd==NR); state <= rnd_out each cycle. If rnd==NR go DONE, else rnd <= rnd+1.
- DONE: out_valid=1, out_data/state held stable until out_ready; on out_ready go IDLE.
- in_ready is 0 in ROUND and DONE; no accept in the same cycle as the DONE->IDLE handoff.
- flush has priority over every transition: next state IDLE, rnd <= 0, state register keeps value, out_valid drops.
- key_ready deasserting in ROUND/DONE is ignored; the key schedule must hold keys stable while busy.
- rnd_final is 0 outside ROUND; rk_idx never exceeds NR.

## Timing
- Reset values: state register 0, rnd 0, FSM IDLE, out_valid 0, out_data 0, rk_idx 0, rnd_final 0, busy 0; in_ready follows key_ready after reset.
- Accept at edge E0 -> rounds at edges E1..E(NR) -> out_valid high from edge E(NR) onward.
- Latency NR cycles accept-to-out_valid; minimum block period NR+2 cycles with out_ready held high.
- out_valid with out_ready low: out_data stable for any number of cycles.
- Reset asserted mid-operation: all outputs return to reset values immediately, no block emitted.

## Configuration
- AES_SEQ_DECRYPT_EN defined: adds input port dec (1 bit, sampled on accept, held internally) and output rnd_dec (registered copy to datapath). With dec=1, whitening uses rk_idx=NR in IDLE and ROUND issues rk_idx = NR-rnd (NR-1 down to 0); rnd_final as above. With dec=0 behaviour is identical to encrypt.
- Not defined: encrypt only; dec and rnd_dec ports absent; rk_idx always ascending.

## Test plan
- FIPS-197 AES-128 (NR=10), key 000102...0f, in_data 00112233445566778899aabbccddeeff, bench-modelled round datapath -> out_valid exactly 10 cycles after accept, out_data 69c4e0d86a7b0430d8cdb78070b4c55a; rk_idx sequence 0,1..10; rnd_final only with rk_idx=10.
- key_ready=0 with in_valid=1 for 5 cycles -> in_ready=0, busy=0; raise key_ready -> accept next edge.
- Back-pressure: out_ready low 7 cycles in DONE -> out_data stable, in_ready 0; out_ready high -> IDLE next edge, second block accepted one cycle later.
- flush asserted at rnd=4 -> IDLE at next edge, out_valid never asserted, fresh block then yields correct ciphertext.
- rst_n pulsed low mid-ROUND -> out_valid, rk_idx, rnd_final, busy all 0 asynchronously; no spurious output after release.
- With AES_SEQ_DECRYPT_EN, dec=1, in_data 69c4e0d86a7b0430d8cdb78070b4c55a -> rk_idx 10,9..0, out_data 00112233445566778899aabbccddeeff.

Source files
------------

// File: rtl/aes_round_sequencer.sv
// Iterative AES round controller: owns the state register, whitens with key 0, then runs NR rounds.
// Latency NR cycles accept-to-out_valid; result held in DONE until out_ready; in_ready low while busy.
// Build option AES_SEQ_DECRYPT_EN adds dec/rnd_dec and descending round-key indices for decryption.
module aes_round_sequencer #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         key_ready,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  output logic [127:0] rnd_state,
  output logic         rnd_final,
  input  logic [127:0] rnd_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
`ifdef AES_SEQ_DECRYPT_EN
  ,
  input  logic         dec,
  output logic         rnd_dec
`endif
);

  localparam logic [3:0] NR_L = 4'(NR);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_e;

  state_e        fsm_q;
  logic [3:0]    rnd_q;
  logic [127:0]  data_q;
  logic          out_valid_q;
  logic          busy_q;
  logic          fin_q;
  logic [3:0]    idx_q;
  logic          dec_q;
  logic          dec_in;
  logic [3:0]    idle_idx;
  logic [3:0]    rnd_inc;

`ifdef AES_SEQ_DECRYPT_EN
  assign dec_in  = dec;
  assign rnd_dec = dec_q;
`else
  assign dec_in  = 1'b0;
`endif

  // Decryption walks the key schedule backwards: round r uses key NR-r.
  function automatic logic [3:0] round_idx(input logic [3:0] r, input logic d);
    return d ? (NR_L - r) : r;
  endfunction

  assign idle_idx = dec_in ? NR_L : 4'd0;
  assign rnd_inc  = rnd_q + 4'd1;

  assign in_ready  = (fsm_q == IDLE) && key_ready && !flush;
  assign rk_idx    = (fsm_q == ROUND) ? idx_q : idle_idx;
  assign rnd_state = data_q;
  assign rnd_final = fin_q;
  assign out_valid = out_valid_q;
  assign out_data  = data_q;
  assign busy      = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      rnd_q       <= 4'd0;
      data_q      <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      fin_q       <= 1'b0;
      idx_q       <= 4'd0;
      dec_q       <= 1'b0;
    end else if (flush) begin
      // Abort keeps the state register contents; only control returns to IDLE.
      fsm_q       <= IDLE;
      rnd_q       <= 4'd0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      fin_q       <= 1'b0;
      idx_q       <= 4'd0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (in_valid && in_ready) begin
            data_q <= in_data ^ rk;
            rnd_q  <= 4'd1;
            fsm_q  <= ROUND;
            busy_q <= 1'b1;
            fin_q  <= (NR_L == 4'd1);
            idx_q  <= round_idx(4'd1, dec_in);
            dec_q  <= dec_in;
          end
        end
        ROUND: begin
          data_q <= rnd_out;
          if (rnd_q == NR_L) begin
            fsm_q       <= DONE;
            out_valid_q <= 1'b1;
            fin_q       <= 1'b0;
            idx_q       <= 4'd0;
          end else begin
            rnd_q <= rnd_inc;
            fin_q <= (rnd_inc == NR_L);
            idx_q <= round_idx(rnd_inc, dec_q);
          end
        end
        DONE: begin
          if (out_ready) begin
            fsm_q       <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: bench-side AES-128 round datapath and key schedule,
// FIPS-197 vector, key gating, back-pressure, flush, async reset and random blocks.
module tb_aes_round_sequencer;
  localparam int NR = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         key_ready = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] in_data = '0;
  logic         in_ready;
  logic [3:0]   rk_idx;
  logic [127:0] rk;
  logic [127:0] rnd_state;
  logic         rnd_final;
  logic [127:0] rnd_out;
  logic         out_valid;
  logic [127:0] out_data;
  logic         busy;
`ifdef AES_SEQ_DECRYPT_EN
  logic         dec = 1'b0;
  logic         rnd_dec;
`endif

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0]   sbox [256];
  logic [127:0] rkeys [16];

  always #5 clk = ~clk;

  aes_round_sequencer #(.NR(NR)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .key_ready (key_ready),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .rk_idx    (rk_idx),
    .rk        (rk),
    .rnd_state (rnd_state),
    .rnd_final (rnd_final),
    .rnd_out   (rnd_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
`ifdef AES_SEQ_DECRYPT_EN
    ,
    .dec       (dec),
    .rnd_dec   (rnd_dec)
`endif
  );

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic fin);
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) b[i] = sbox[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) t[r+4*c] = b[r+4*((c+r)%4)];
    if (!fin) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
        t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
        t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
        t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = t[i];
    return res ^ k;
  endfunction

  // Whole-block reference: whitening then NR rounds, last one without MixColumns.
  function automatic logic [127:0] aes_encrypt(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ rkeys[0];
    for (int r = 1; r <= NR; r++) s = aes_round(s, rkeys[r], r == NR);
    return s;
  endfunction

  task automatic build_sbox;
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic key_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++)
      rkeys[r] = (r <= NR) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
  endtask

  always_comb rk = rkeys[rk_idx];
  always_comb rnd_out = aes_round(rnd_state, rk, rnd_final);

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_block(input logic [127:0] pt);
    in_valid = 1'b1;
    in_data  = pt;
    #1;
    chk1("in_ready_idle", in_ready, 1'b1);
    chk4("rk_idx_whiten", rk_idx, 4'd0);
    tick;
    in_valid = 1'b0;
  endtask

  // Expected key index k on the k-th cycle after accept; result visible after exactly NR edges.
  task automatic rounds_check;
    for (int k = 1; k <= NR; k++) begin
      chk1("out_valid_early", out_valid, 1'b0);
      chk1("busy_round", busy, 1'b1);
      chk1("in_ready_round", in_ready, 1'b0);
      chk4("rk_idx_round", rk_idx, 4'(k));
      chk1("rnd_final", rnd_final, k == NR);
      tick;
    end
    chk1("out_valid_latency", out_valid, 1'b1);
    chk1("rnd_final_done", rnd_final, 1'b0);
  endtask

  task automatic drain(input logic [127:0] exp, input int hold, input logic nxt_vld,
                       input logic [127:0] nxt_pt);
    out_ready = 1'b0;
    in_valid  = nxt_vld;
    in_data   = nxt_pt;
    for (int h = 0; h < hold; h++) begin
      #1;
      chk("out_data_hold", out_data, exp);
      chk1("out_valid_hold", out_valid, 1'b1);
      chk1("in_ready_done", in_ready, 1'b0);
      tick;
    end
    out_ready = 1'b1;
    #1;
    chk("out_data", out_data, exp);
    chk1("out_valid_handoff", out_valid, 1'b1);
    chk1("in_ready_handoff", in_ready, 1'b0);
    tick;
    out_ready = 1'b0;
    #1;
    chk1("busy_idle", busy, 1'b0);
    chk1("out_valid_idle", out_valid, 1'b0);
    chk1("in_ready_after_done", in_ready, 1'b1);
  endtask

  task automatic watch_quiet(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      if (out_valid !== 1'b0) seen = 1'b1;
      tick;
    end
    chk1(tag, seen, 1'b0);
  endtask

  function automatic logic [127:0] rnd128;
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] pt, pt2, key;
    int hold;

    build_sbox;
    key_expand(128'h000102030405060708090a0b0c0d0e0f);

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_rnd_state", rnd_state, '0);
    chk4("rst_rk_idx", rk_idx, 4'd0);
    chk1("rst_rnd_final", rnd_final, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_in_ready_lo", in_ready, 1'b0);
    key_ready = 1'b1;
    #1;
    chk1("rst_in_ready_hi", in_ready, 1'b1);
    key_ready = 1'b0;
    rst_n = 1'b1;
    tick;

    // Key schedule not ready: block is offered but must not be taken
    pt = 128'h00112233445566778899aabbccddeeff;
    in_valid = 1'b1;
    in_data  = pt;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk1("keygate_in_ready", in_ready, 1'b0);
      chk1("keygate_busy", busy, 1'b0);
      tick;
    end
    key_ready = 1'b1;

    // FIPS-197 vector with 7 cycles of back-pressure, then back-to-back block
    pt2 = rnd128();
    start_block(pt);
    rounds_check;
    drain(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 7, 1'b1, pt2);
    start_block(pt2);
    rounds_check;
    drain(aes_encrypt(pt2), 0, 1'b0, '0);

    // Flush at round 4
    start_block(rnd128());
    repeat (3) tick;
    chk4("flush_at_rnd4", rk_idx, 4'd4);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    chk1("flush_busy", busy, 1'b0);
    chk1("flush_out_valid", out_valid, 1'b0);
    chk1("flush_rnd_final", rnd_final, 1'b0);
    chk4("flush_rk_idx", rk_idx, 4'd0);
    watch_quiet("flush_no_output", 15);
    pt = rnd128();
    start_block(pt);
    rounds_check;
    drain(aes_encrypt(pt), 1, 1'b0, '0);

    // Asynchronous reset mid-round
    start_block(rnd128());
    repeat (2) tick;
    #2;
    rst_n = 1'b0;
    #1;
    chk1("arst_out_valid", out_valid, 1'b0);
    chk4("arst_rk_idx", rk_idx, 4'd0);
    chk1("arst_rnd_final", rnd_final, 1'b0);
    chk1("arst_busy", busy, 1'b0);
    chk("arst_out_data", out_data, '0);
    tick;
    rst_n = 1'b1;
    watch_quiet("arst_no_output", 15);
    pt = rnd128();
    start_block(pt);
    rounds_check;
    drain(aes_encrypt(pt), 2, 1'b0, '0);

    // Random keys and blocks with random back-pressure
    for (int b = 0; b < 6; b++) begin
      key_ready = 1'b0;
      key = rnd128();
      key_expand(key);
      tick;
      key_ready = 1'b1;
      pt = rnd128();
      hold = int'($urandom_range(0, 3));
      start_block(pt);
      rounds_check;
      drain(aes_encrypt(pt), hold, 1'b0, '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
